// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver.
// Drives DIGITS digits one slot at a time with a dead time at the start of
// each slot, hex font, per-digit decimal point, blanking and blink, plus a
// PASS/FAIL overlay that replaces every digit with a fixed glyph.
module seg_scan_display #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned SCAN_DIV       = 270,
    parameter int unsigned DEADTIME       = 8,
    parameter int unsigned BLINK_DIV      = 25000,
    parameter logic [3:0]  PASS_CODE      = 4'h8,
    parameter logic [3:0]  FAIL_CODE      = 4'h7,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_en,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  result_valid,
    input  logic                  result_pass,
    input  logic                  clear,
    output logic [1:0]            status,
    output logic [7:0]            smg,
    output logic [DIGITS-1:0]     dig
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam int unsigned SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Status encoding doubles as the state encoding.
    localparam logic [1:0] ST_NORMAL = 2'b00;
    localparam logic [1:0] ST_PASS   = 2'b01;
    localparam logic [1:0] ST_FAIL   = 2'b10;

    logic [PW-1:0]     presc_q, presc_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic [FW-1:0]     frame_q, frame_d;
    logic              blink_q, blink_d;
    logic [1:0]        state_q, state_d;
    logic              tick, sel_last, in_dead;

    logic [3:0]        cur_nib;
    logic              cur_dp, cur_blank, cur_blink;
    logic [DIGITS-1:0] sel_oh;
    logic [DIGITS-1:0] dig_d;
    logic [7:0]        smg_d;

    // Active-high hex font, segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Slot timing: prescaler, digit select, frame counter and blink phase.
    always_comb begin
        tick     = (presc_q == PW'(SCAN_DIV - 1));
        sel_last = (sel_q == SW'(DIGITS - 1));
        in_dead  = (32'(presc_q) < DEADTIME);
        presc_d  = tick ? '0 : presc_q + PW'(1);
        sel_d    = sel_q;
        frame_d  = frame_q;
        blink_d  = blink_q;
        if (tick) begin
            // Explicit wrap keeps sel in range for non-power-of-2 DIGITS.
            sel_d = sel_last ? '0 : sel_q + SW'(1);
            if (sel_last) begin
                if (frame_q == FW'(BLINK_DIV - 1)) begin
                    frame_d = '0;
                    blink_d = ~blink_q;
                end else begin
                    frame_d = frame_q + FW'(1);
                end
            end
        end
    end

    // Result overlay state: a new result wins over a simultaneous clear.
    always_comb begin
        state_d = state_q;
        if (result_valid) begin
            state_d = result_pass ? ST_PASS : ST_FAIL;
        end else if (clear) begin
            state_d = ST_NORMAL;
        end
    end

    // Pick the per-digit controls of the selected digit (live inputs).
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        sel_oh    = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (sel_q == SW'(i)) begin
                cur_nib   = data[4*i +: 4];
                cur_dp    = dp_en[i];
                cur_blank = blank[i];
                cur_blink = blink_en[i];
                sel_oh[i] = 1'b1;
            end
        end
    end

    // Active-high next values for the digit enables and segments.
    always_comb begin
        dig_d = '0;
        smg_d = 8'h00;
        if (!in_dead) begin
            if (state_q == ST_PASS) begin
                dig_d = sel_oh;
                smg_d = {1'b0, hex_font(PASS_CODE)};
            end else if (state_q == ST_FAIL) begin
                dig_d = sel_oh;
                smg_d = {1'b0, hex_font(FAIL_CODE)};
            end else if (!(cur_blank || (cur_blink && blink_q))) begin
                dig_d = sel_oh;
                smg_d = {cur_dp, hex_font(cur_nib)};
            end
        end
    end

    // State registers; outputs are stored with polarity already applied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sel_q   <= '0;
            frame_q <= '0;
            blink_q <= 1'b0;
            state_q <= ST_NORMAL;
            dig     <= {DIGITS{DIG_ACTIVE_LOW}};
            smg     <= {8{SEG_ACTIVE_LOW}};
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            state_q <= state_d;
            dig     <= dig_d ^ {DIGITS{DIG_ACTIVE_LOW}};
            smg     <= smg_d ^ {8{SEG_ACTIVE_LOW}};
        end
    end

    assign status = state_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: two instances (4 digits active-low, 3 digits
// active-high) share stimulus; a cycle-count based model predicts every output.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = 32'h0;
    logic [7:0]  dp_en = 8'h0, blank = 8'h0, blink_en = 8'h0;
    logic        result_valid = 1'b0, result_pass = 1'b0, clear = 1'b0;

    logic [1:0]  status_a, status_b;
    logic [7:0]  smg_a, smg_b;
    logic [3:0]  dig_a;
    logic [2:0]  dig_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    seg_scan_display #(
        .DIGITS(4), .SCAN_DIV(10), .DEADTIME(2), .BLINK_DIV(2),
        .PASS_CODE(4'h8), .FAIL_CODE(4'h7), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .data(data[15:0]), .dp_en(dp_en[3:0]), .blank(blank[3:0]),
        .blink_en(blink_en[3:0]), .result_valid(result_valid), .result_pass(result_pass),
        .clear(clear), .status(status_a), .smg(smg_a), .dig(dig_a)
    );

    seg_scan_display #(
        .DIGITS(3), .SCAN_DIV(10), .DEADTIME(2), .BLINK_DIV(1),
        .PASS_CODE(4'h5), .FAIL_CODE(4'hE), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .data(data[11:0]), .dp_en(dp_en[2:0]), .blank(blank[2:0]),
        .blink_en(blink_en[2:0]), .result_valid(result_valid), .result_pass(result_pass),
        .clear(clear), .status(status_b), .smg(smg_b), .dig(dig_b)
    );

    function automatic logic [6:0] font7(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h3F; 4'h1: f = 7'h06; 4'h2: f = 7'h5B; 4'h3: f = 7'h4F;
            4'h4: f = 7'h66; 4'h5: f = 7'h6D; 4'h6: f = 7'h7D; 4'h7: f = 7'h07;
            4'h8: f = 7'h7F; 4'h9: f = 7'h6F; 4'hA: f = 7'h77; 4'hB: f = 7'h7C;
            4'hC: f = 7'h39; 4'hD: f = 7'h5E; 4'hE: f = 7'h79; default: f = 7'h71;
        endcase
        return f;
    endfunction

    // Outputs shown after t clock edges of scanning, from plain arithmetic on t.
    // Returns {dig (8b, polarity applied, masked), smg}.
    function automatic logic [15:0] model(input int t, input int nd, input int sd, input int dt,
                                          input int bd, input logic [1:0] st,
                                          input logic [31:0] dat, input logic [7:0] dp,
                                          input logic [7:0] bl, input logic [7:0] bk,
                                          input logic [3:0] pc, input logic [3:0] fc,
                                          input bit sl, input bit dl);
        int presc, slot, sel, frame, phase;
        logic [7:0] d, s, mask;
        presc = t % sd;
        slot  = t / sd;
        sel   = slot % nd;
        frame = slot / nd;
        phase = (frame / bd) % 2;
        d     = 8'h00;
        s     = 8'h00;
        mask  = 8'hFF >> (8 - nd);
        if (presc >= dt) begin
            if (st == 2'b01) begin
                d[sel] = 1'b1;
                s = {1'b0, font7(pc)};
            end else if (st == 2'b10) begin
                d[sel] = 1'b1;
                s = {1'b0, font7(fc)};
            end else if (!(bl[sel] || (bk[sel] && phase == 1))) begin
                d[sel] = 1'b1;
                s = {dp[sel], font7(dat[4*sel +: 4])};
            end
        end
        if (dl) d = ~d & mask;
        if (sl) s = ~s;
        return {d, s};
    endfunction

    int          t_m = 0;
    logic [1:0]  st_m = 2'b00;
    logic [15:0] exp_a = {8'h0F, 8'hFF};
    logic [15:0] exp_b = 16'h0000;

    // Model: advances one edge per clock, reset with the DUT.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t_m   <= 0;
            st_m  <= 2'b00;
            exp_a <= {8'h0F, 8'hFF};
            exp_b <= 16'h0000;
        end else begin
            exp_a <= model(t_m, 4, 10, 2, 2, st_m, data, dp_en, blank, blink_en,
                           4'h8, 4'h7, 1'b1, 1'b1);
            exp_b <= model(t_m, 3, 10, 2, 1, st_m, data, dp_en, blank, blink_en,
                           4'h5, 4'hE, 1'b0, 1'b0);
            t_m   <= t_m + 1;
            st_m  <= result_valid ? (result_pass ? 2'b01 : 2'b10) : (clear ? 2'b00 : st_m);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("dig_a", {24'h0, 4'h0, dig_a}, {24'h0, exp_a[15:8]});
            check("smg_a", {24'h0, smg_a}, {24'h0, exp_a[7:0]});
            check("status_a", {30'h0, status_a}, {30'h0, st_m});
            check("dig_b", {24'h0, 5'h0, dig_b}, {24'h0, exp_b[15:8]});
            check("smg_b", {24'h0, smg_b}, {24'h0, exp_b[7:0]});
            check("status_b", {30'h0, status_b}, {30'h0, st_m});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the edge after which t_m % modv == m (bounded).
    task automatic wait_t(input int modv, input int m);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk);
            #1;
            if (t_m % modv == m) found = 1'b1;
        end
        if (!found) begin
            n_total++;
            $display("FAIL wait_t: window %0d mod %0d not reached", m, modv);
        end
    endtask

    task automatic pulse_result(input logic pass, input logic clr, input logic [1:0] exp_st);
        @(negedge clk);
        result_valid = 1'b1;
        result_pass  = pass;
        clear        = clr;
        @(posedge clk);
        #1;
        check("pulse_status_a", {30'h0, status_a}, {30'h0, exp_st});
        check("pulse_status_b", {30'h0, status_b}, {30'h0, exp_st});
        @(negedge clk);
        result_valid = 1'b0;
        clear        = 1'b0;
    endtask

    initial begin
        data = 32'h0000_3210;
        #12;
        check("rst_dig_a", {28'h0, dig_a}, 32'hF);
        check("rst_smg_a", {24'h0, smg_a}, 32'hFF);
        check("rst_dig_b", {29'h0, dig_b}, 32'h0);
        check("rst_smg_b", {24'h0, smg_b}, 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // First lit slot: digit 0 after dead time, then digit 1 one slot later.
        repeat (3) @(posedge clk);
        #1;
        check("lit0_dig_a", {28'h0, dig_a}, 32'hE);
        check("lit0_smg_a", {24'h0, smg_a}, 32'hC0);
        check("lit0_dig_b", {29'h0, dig_b}, 32'h1);
        check("lit0_smg_b", {24'h0, smg_b}, 32'h3F);
        repeat (10) @(posedge clk);
        #1;
        check("lit1_dig_a", {28'h0, dig_a}, 32'hD);
        check("lit1_smg_a", {24'h0, smg_a}, 32'hF9);
        check("lit1_dig_b", {29'h0, dig_b}, 32'h2);
        check("lit1_smg_b", {24'h0, smg_b}, 32'h06);
        @(negedge clk);
        cycles(100);

        // Blank digit 2, dp on digit 0.
        data  = 32'h0000_FEDC;
        blank = 8'b0000_0100;
        dp_en = 8'b0000_0001;
        cycles(160);
        wait_t(40, 3);
        check("dp0_smg_a", {24'h0, smg_a}, 32'h46);
        check("dp0_dig_a", {28'h0, dig_a}, 32'hE);
        wait_t(40, 33);
        check("d3_smg_a", {24'h0, smg_a}, 32'h8E);
        check("d3_dig_a", {28'h0, dig_a}, 32'h7);

        // Blink digit 1.
        @(negedge clk);
        data     = 32'h0000_3210;
        blank    = 8'h00;
        dp_en    = 8'h00;
        blink_en = 8'b0000_0010;
        cycles(200);
        wait_t(160, 93);
        check("blink_dark_dig_a", {28'h0, dig_a}, 32'hF);
        check("blink_dark_smg_a", {24'h0, smg_a}, 32'hFF);
        wait_t(160, 13);
        check("blink_lit_dig_a", {28'h0, dig_a}, 32'hD);
        check("blink_lit_smg_a", {24'h0, smg_a}, 32'hF9);
        @(negedge clk);
        blink_en = 8'h00;

        // Result overlay.
        pulse_result(1'b1, 1'b0, 2'b01);
        cycles(40);
        wait_t(40, 3);
        check("pass_smg_a", {24'h0, smg_a}, 32'h80);
        check("pass_dig_a", {28'h0, dig_a}, 32'hE);
        pulse_result(1'b0, 1'b0, 2'b10);
        cycles(40);
        wait_t(40, 13);
        check("fail_smg_a", {24'h0, smg_a}, 32'hF8);
        check("fail_dig_a", {28'h0, dig_a}, 32'hD);
        pulse_result(1'b1, 1'b1, 2'b01);
        cycles(20);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_status_a", {30'h0, status_a}, 32'h0);
        @(negedge clk);
        clear = 1'b0;
        cycles(20);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        cycles(20);

        // Async reset mid-slot while in FAIL.
        pulse_result(1'b0, 1'b0, 2'b10);
        wait_t(40, 5);
        #1;
        rst = 1'b1;
        #1;
        check("arst_dig_a", {28'h0, dig_a}, 32'hF);
        check("arst_smg_a", {24'h0, smg_a}, 32'hFF);
        check("arst_status_a", {30'h0, status_a}, 32'h0);
        check("arst_dig_b", {29'h0, dig_b}, 32'h0);
        check("arst_smg_b", {24'h0, smg_b}, 32'h00);
        check("arst_status_b", {30'h0, status_b}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("restart_dig_a", {28'h0, dig_a}, 32'hE);
        check("restart_smg_a", {24'h0, smg_a}, 32'hC0);
        check("restart_dig_b", {29'h0, dig_b}, 32'h1);
        @(negedge clk);
        cycles(60);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
